// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Mul uses shift-add, div uses restoring shift-subtract, both over WIDTH cycles on magnitudes.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               issue_md;
    logic               mt_hi;
    logic               mt_lo;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH-1:0]   quot_neg;
    logic [WIDTH-1:0]   rem_neg;

    assign busy      = (state != IDLE);
    assign issue_md  = (state == IDLE) && start && !flush && !op[2];
    assign mt_hi     = (state == IDLE) && start && !flush && (op == 3'b100);
    assign mt_lo     = (state == IDLE) && start && !flush && (op == 3'b101);
    assign signed_op = !op[0];
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign acc_neg   = -acc;
    assign quot_neg  = -acc[WIDTH-1:0];
    assign rem_neg   = -acc[2*WIDTH-1:WIDTH];

    // acc holds {partial product, remaining multiplier bits} for mul and {remainder, dividend bits} for div
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !op[2]) next_state = CALC;
            CALC:    if (count == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= (state == FIX) && !flush;

            if (issue_md) begin
                count    <= CNT_W'(WIDTH - 1);
                is_div   <= op[1];
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (b == '0);
                if (op[1]) begin
                    acc  <= {{WIDTH{1'b0}}, a_mag};
                    opnd <= b_mag;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, b_mag};
                    opnd <= a_mag;
                end
            end else if (state == CALC) begin
                count <= count - CNT_W'(1);
                acc   <= is_div ? div_next : mul_next;
            end

            // Divide by zero leaves the raw remainder (= dividend) but forces an all-ones quotient
            if ((state == FIX) && !flush) begin
                if (is_div) begin
                    lo <= div_zero ? {WIDTH{1'b1}} : (neg_res ? quot_neg : acc[WIDTH-1:0]);
                    hi <= neg_rem ? rem_neg : acc[2*WIDTH-1:WIDTH];
                end else begin
                    {hi, lo} <= neg_res ? acc_neg : acc;
                end
            end else if (mt_hi) begin
                hi <= a;
            end else if (mt_lo) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: 64-bit reference model feeding a scoreboard queue.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          checks;
    int          errors;
    int          last_latency;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        longint      sx;
        longint      sy;
        longint      p;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.hi = model_hi;
        r.lo = model_lo;
        case (o)
            3'b000: begin
                p = sx * sy;
                {r.hi, r.lo} = p;
            end
            3'b001: begin
                u = {32'b0, x} * {32'b0, y};
                {r.hi, r.lo} = u;
            end
            3'b010: begin
                if (y == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = x;
                end else begin
                    p = sx / sy;
                    r.lo = p[31:0];
                    p = sx % sy;
                    r.hi = p[31:0];
                end
            end
            3'b011: begin
                if (y == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = x;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Drives one start pulse; returns at the negedge just after the issue edge
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (!o[2]) exp_q.push_back(model(o, x, y));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int   cycles;
        bit   seen;
        bit   busy_ok;
        bit   hold_ok;
        exp_t e;
        cycles  = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!seen && cycles < 100) begin
            @(posedge clk);
            cycles++;
            #1;
            if (done) begin
                seen = 1'b1;
                if (busy) busy_ok = 1'b0;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (hi !== model_hi || lo !== model_lo) hold_ok = 1'b0;
            end
        end
        last_latency = cycles;
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
        checkOutput({tag, "_hold_hilo"}, 64'(hold_ok), 64'd1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({tag, "_hi"}, 64'(hi), 64'(e.hi));
            checkOutput({tag, "_lo"}, 64'(lo), 64'(e.lo));
            model_hi = e.hi;
            model_lo = e.lo;
        end else begin
            checkOutput({tag, "_no_result"}, 64'(exp_q.size()), 64'd9999);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        model_hi = '0;
        model_lo = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 3'b000;
        a        = '0;
        b        = '0;
        flush    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed mul/div");
        applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd5);
        waitResult("mult_neg");
        checkOutput("mult_latency", 64'(last_latency), 64'd34);
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitResult("multu_max");
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
        waitResult("div_neg");
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        waitResult("div_wrap");
        applyStimulus(3'b011, 32'd100, 32'd0);
        waitResult("divu_zero");
        applyStimulus(3'b010, 32'hFFFF_FF9C, 32'd0);
        waitResult("div_zero_neg");

        $display("[TB] moves and undefined op");
        applyStimulus(3'b100, 32'h0000_1234, 32'd0);
        checkOutput("mthi_hi", 64'(hi), 64'h1234);
        checkOutput("mthi_lo", 64'(lo), 64'(model_lo));
        checkOutput("mthi_done", 64'(done), 64'd0);
        checkOutput("mthi_busy", 64'(busy), 64'd0);
        model_hi = 32'h0000_1234;
        applyStimulus(3'b101, 32'hCAFE_0001, 32'd0);
        checkOutput("mtlo_lo", 64'(lo), 64'hCAFE_0001);
        model_lo = 32'hCAFE_0001;
        applyStimulus(3'b110, 32'hDEAD_BEEF, 32'd3);
        checkOutput("undef_busy", 64'(busy), 64'd0);
        checkOutput("undef_hilo", {hi, lo}, {model_hi, model_lo});

        $display("[TB] start ignored while busy");
        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFE);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        a     = 32'h5555_AAAA;
        b     = 32'd1;
        @(negedge clk);
        op    = 3'b011;
        @(negedge clk);
        start = 1'b0;
        waitResult("busy_ignore");

        $display("[TB] flush mid-op and during FIX");
        applyStimulus(3'b000, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) checkOutput("flush_spurious_done", 64'(done), 64'd0);
        end
        checkOutput("flush_hilo", {hi, lo}, {model_hi, model_lo});

        applyStimulus(3'b001, 32'd99, 32'd3);
        repeat (32) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_fix_done", 64'(done), 64'd0);
        checkOutput("flush_fix_busy", 64'(busy), 64'd0);
        checkOutput("flush_fix_hilo", {hi, lo}, {model_hi, model_lo});
        @(negedge clk);
        exp_q.delete();
        start = 1'b1;
        op    = 3'b001;
        a     = 32'd4;
        b     = 32'd4;
        @(posedge clk);
        #1;
        checkOutput("flush_start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;

        $display("[TB] async reset mid-op");
        applyStimulus(3'b010, 32'd1000, 32'd7);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_hilo", {hi, lo}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        waitResult("multu_after_rst");

        $display("[TB] random ops");
        for (int i = 0; i < 6; i++) begin
            logic [2:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = (i == 2) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 9)) : $urandom);
            applyStimulus(o, x, y);
            waitResult("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
